// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: on a CPU write to the DMA register it halts the CPU and copies
// one page of memory into OAMDATA. The bus is CPU pass-through when idle and DMA-driven when busy.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
    parameter int unsigned XFER_LEN     = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clock_en,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_r_en,
    input  logic [7:0]  cpu_w_data,
    input  logic [7:0]  mem_r_data,
    output logic [15:0] mem_addr,
    output logic        mem_r_en,
    output logic [7:0]  mem_w_data,
    output logic        cpu_halt,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state;
    logic [7:0] page;
    logic [7:0] idx;
    logic       parity;

    // Sequencer; parity tracks CPU get/put cycles so reads land on the correct phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            parity <= 1'b0;
        end else if (clock_en) begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (cpu_addr == DMA_REG_ADDR && !cpu_r_en) begin
                        page  <= cpu_w_data;
                        idx   <= 8'h00;
                        state <= HALT;
                    end
                end
                HALT:  state <= parity ? ALIGN : READ;
                ALIGN: state <= READ;
                READ:  state <= WRITE;
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        idx   <= 8'h00;
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus mux decoded from held state so halt releases on the first idle cycle.
    always_comb begin
        mem_addr   = cpu_addr;
        mem_r_en   = cpu_r_en;
        mem_w_data = cpu_w_data;
        cpu_halt   = 1'b0;
        dma_active = 1'b0;
        case (state)
            HALT, ALIGN: begin
                cpu_halt   = 1'b1;
                mem_r_en   = 1'b1;
                mem_w_data = 8'h00;
            end
            READ: begin
                cpu_halt   = 1'b1;
                dma_active = 1'b1;
                mem_addr   = {page, idx};
                mem_r_en   = 1'b1;
                mem_w_data = 8'h00;
            end
            WRITE: begin
                cpu_halt   = 1'b1;
                dma_active = 1'b1;
                mem_addr   = OAMDATA_ADDR;
                mem_r_en   = 1'b0;
                mem_w_data = mem_r_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: a behavioural memory plus transfer expectations
// derived from page contents, CPU-cycle parity and enabled-cycle counts.
module tb_oam_dma_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        clock_en;
    logic [15:0] cpu_addr;
    logic        cpu_r_en;
    logic [7:0]  cpu_w_data;
    logic [7:0]  mem_r_data;
    logic [15:0] mem_addr;
    logic        mem_r_en;
    logic [7:0]  mem_w_data;
    logic        cpu_halt;
    logic        dma_active;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ram [0:65535];
    int          en_count  = 0;
    int          halt_cnt  = 0;
    int          nodma_cnt = 0;
    int          bad_dst   = 0;
    logic [7:0]  wq [$];
    logic [15:0] rq [$];

    oam_dma_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .clock_en   (clock_en),
        .cpu_addr   (cpu_addr),
        .cpu_r_en   (cpu_r_en),
        .cpu_w_data (cpu_w_data),
        .mem_r_data (mem_r_data),
        .mem_addr   (mem_addr),
        .mem_r_en   (mem_r_en),
        .mem_w_data (mem_w_data),
        .cpu_halt   (cpu_halt),
        .dma_active (dma_active)
    );

    always #5 clock = ~clock;

    // Memory model and bus observer; each enabled cycle is recorded mid-cycle.
    always @(negedge clock) begin
        if (reset) begin
            en_count = 0;
        end else if (clock_en) begin
            en_count++;
            if (cpu_halt) halt_cnt++;
            if (cpu_halt && !dma_active) nodma_cnt++;
            if (dma_active) begin
                if (mem_r_en) rq.push_back(mem_addr);
                else begin
                    if (mem_addr !== 16'h2004) bad_dst++;
                    wq.push_back(mem_w_data);
                end
            end
            if (mem_r_en) mem_r_data <= ram[mem_addr];
            else          ram[mem_addr] <= mem_w_data;
        end
    end

    task automatic tick(input logic en);
        clock_en = en;
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        cpu_addr   = 16'h0000;
        cpu_r_en   = 1'b1;
        cpu_w_data = 8'h00;
    endtask

    task automatic clear_obs();
        halt_cnt  = 0;
        nodma_cnt = 0;
        bad_dst   = 0;
        wq.delete();
        rq.delete();
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        clock_en   = 1'b0;
        cpu_addr   = 16'h1234;
        cpu_r_en   = 1'b0;
        cpu_w_data = 8'h9C;
        mem_r_data = 8'h00;
        #1;
        tick(1'b1);
        tick(1'b1);
        checks++;
        if ({mem_addr, mem_r_en, mem_w_data, cpu_halt, dma_active} !== {cpu_addr, cpu_r_en, cpu_w_data, 2'b00}) begin
            failures++;
            $display("FAIL reset_outputs: addr=%h r_en=%b wdata=%h halt=%b act=%b, required pass-through of %h/%b/%h with halt=0 act=0",
                     mem_addr, mem_r_en, mem_w_data, cpu_halt, dma_active, cpu_addr, cpu_r_en, cpu_w_data);
        end
        bus_idle();
        reset = 1'b0;
        tick(1'b1);
    endtask

    task automatic test_passthrough();
        logic [15:0] a [0:1];
        logic        r [0:1];
        logic [7:0]  d [0:1];
        a[0] = 16'h8000; r[0] = 1'b1; d[0] = 8'h00;
        a[1] = 16'h0010; r[1] = 1'b0; d[1] = 8'h55;
        clear_obs();
        for (int i = 0; i < 12; i++) begin
            if (i < 2) begin
                cpu_addr = a[i]; cpu_r_en = r[i]; cpu_w_data = d[i];
            end else begin
                cpu_addr   = 16'($urandom_range(16'h4000, 16'hFFFF));
                cpu_r_en   = 1'($urandom);
                cpu_w_data = 8'($urandom);
            end
            #1;
            checks++;
            if ({mem_addr, mem_r_en, mem_w_data, cpu_halt} !== {cpu_addr, cpu_r_en, cpu_w_data, 1'b0}) begin
                failures++;
                $display("FAIL passthrough[%0d]: got %h/%b/%h halt=%b, required %h/%b/%h halt=0",
                         i, mem_addr, mem_r_en, mem_w_data, cpu_halt, cpu_addr, cpu_r_en, cpu_w_data);
            end
            tick(1'b1);
        end
        bus_idle();
        checks++;
        if (ram[16'h0010] !== 8'h55) begin
            failures++;
            $display("FAIL passthrough_write: ram[0010]=%h required 55", ram[16'h0010]);
        end
        checks++;
        if (halt_cnt != 0 || rq.size() != 0 || wq.size() != 0) begin
            failures++;
            $display("FAIL passthrough_no_dma: halt=%0d reads=%0d writes=%0d required 0/0/0", halt_cnt, rq.size(), wq.size());
        end
    endtask

    // One full transfer; expectations come from the page contents and the CPU-cycle parity.
    task automatic test_transfer(input string name, input logic [7:0] page, input logic patterned,
                                 input logic want_align, input int en_period);
        logic [7:0] exp [0:255];
        int         exp_halt;
        int         exp_nodma;
        int         cyc;
        logic       timed_out;
        bus_idle();
        if ((en_count % 2 == 0) != want_align) tick(1'b1);
        exp_nodma = (en_count % 2 == 0) ? 2 : 1;
        exp_halt  = 512 + exp_nodma;
        clear_obs();
        cpu_addr = 16'h4014; cpu_r_en = 1'b0; cpu_w_data = page;
        tick(1'b1);
        for (int i = 0; i < 256; i++) begin
            exp[i] = patterned ? (8'(i) ^ 8'hA5) : 8'($urandom);
            ram[{page, 8'(i)}] = exp[i];
        end
        checks++;
        if (cpu_halt !== 1'b1) begin
            failures++;
            $display("FAIL %s_halt_start: cpu_halt=%b required 1", name, cpu_halt);
        end
        cyc = 0;
        timed_out = 1'b0;
        while (cpu_halt === 1'b1 && !timed_out) begin
            cpu_addr   = 16'($urandom);
            cpu_r_en   = 1'($urandom);
            cpu_w_data = 8'($urandom);
            if (cyc % 7 == 3) begin cpu_addr = 16'h4014; cpu_r_en = 1'b0; end
            tick((cyc % en_period) == 0);
            cyc++;
            if (cyc > 4000) timed_out = 1'b1;
        end
        bus_idle();
        #1;
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL %s_timeout: halt still %b after %0d cycles, required release", name, cpu_halt, cyc);
        end
        checks++;
        if (halt_cnt != exp_halt) begin
            failures++;
            $display("FAIL %s_halt_len: %0d enabled halt cycles, required %0d", name, halt_cnt, exp_halt);
        end
        checks++;
        if (nodma_cnt != exp_nodma) begin
            failures++;
            $display("FAIL %s_align: %0d halt/align cycles, required %0d", name, nodma_cnt, exp_nodma);
        end
        checks++;
        if (wq.size() != 256 || rq.size() != 256 || bad_dst != 0) begin
            failures++;
            $display("FAIL %s_counts: writes=%0d reads=%0d bad_dst=%0d, required 256/256/0", name, wq.size(), rq.size(), bad_dst);
        end
        for (int i = 0; i < 256 && i < wq.size() && i < rq.size(); i++) begin
            checks++;
            if (rq[i] !== {page, 8'(i)} || wq[i] !== exp[i]) begin
                failures++;
                $display("FAIL %s_byte[%0d]: read %h data %h, required read %h data %h", name, i, rq[i], wq[i], {page, 8'(i)}, exp[i]);
            end
        end
        checks++;
        if ({mem_addr, mem_r_en, mem_w_data, dma_active} !== {cpu_addr, cpu_r_en, cpu_w_data, 1'b0}) begin
            failures++;
            $display("FAIL %s_release: got %h/%b/%h act=%b, required pass-through act=0", name, mem_addr, mem_r_en, mem_w_data, dma_active);
        end
        tick(1'b1);
    endtask

    task automatic test_reset_mid();
        int   cyc;
        logic found;
        bus_idle();
        clear_obs();
        cpu_addr = 16'h4014; cpu_r_en = 1'b0; cpu_w_data = 8'h07;
        tick(1'b1);
        bus_idle();
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 1000) begin
            if (dma_active === 1'b1 && mem_r_en === 1'b0 && rq.size() == 65) found = 1'b1;
            else begin tick(1'b1); cyc++; end
        end
        checks++;
        if (!found || rq[64] !== 16'h0740) begin
            failures++;
            $display("FAIL reset_mid_reach: found=%b reads=%0d, required WRITE of idx 40 on page 07", found, rq.size());
        end
        reset = 1'b1;
        cpu_addr = 16'h3000; cpu_r_en = 1'b0; cpu_w_data = 8'h3C;
        #1;
        checks++;
        if ({mem_addr, mem_r_en, mem_w_data, cpu_halt, dma_active} !== {16'h3000, 1'b0, 8'h3C, 2'b00}) begin
            failures++;
            $display("FAIL reset_mid_abort: got %h/%b/%h halt=%b act=%b, required 3000/0/3c halt=0 act=0",
                     mem_addr, mem_r_en, mem_w_data, cpu_halt, dma_active);
        end
        tick(1'b1);
        bus_idle();
        reset = 1'b0;
        tick(1'b1);
        checks++;
        if ({mem_addr, mem_r_en, cpu_halt, dma_active} !== {16'h0000, 1'b1, 2'b00}) begin
            failures++;
            $display("FAIL reset_mid_idle: got %h/%b halt=%b act=%b, required idle pass-through", mem_addr, mem_r_en, cpu_halt, dma_active);
        end
        test_transfer("restart", 8'h40, 1'b0, 1'($urandom), 1);
    endtask

    task automatic test_no_trigger();
        bus_idle();
        clear_obs();
        for (int i = 0; i < 30; i++) begin
            case (i % 3)
                0: begin cpu_addr = 16'h4014; cpu_r_en = 1'b1; end
                1: begin cpu_addr = 16'h4015; cpu_r_en = 1'b0; end
                default: begin
                    cpu_addr = 16'($urandom);
                    if (cpu_addr == 16'h4014) cpu_addr = 16'h4013;
                    cpu_r_en = 1'b0;
                end
            endcase
            cpu_w_data = 8'($urandom);
            tick(1'($urandom));
            checks++;
            if (cpu_halt !== 1'b0 || dma_active !== 1'b0) begin
                failures++;
                $display("FAIL no_trigger[%0d]: halt=%b act=%b after %h r_en=%b, required 0/0", i, cpu_halt, dma_active, cpu_addr, cpu_r_en);
            end
        end
        bus_idle();
        checks++;
        if (halt_cnt != 0 || rq.size() != 0 || wq.size() != 0) begin
            failures++;
            $display("FAIL no_trigger_dma: halt=%0d reads=%0d writes=%0d required 0/0/0", halt_cnt, rq.size(), wq.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        test_reset();
        test_passthrough();
        test_transfer("even", 8'h02, 1'b1, 1'b0, 1);
        test_transfer("odd", 8'h02, 1'b1, 1'b1, 1);
        test_transfer("thr_even", 8'h02, 1'b1, 1'b0, 3);
        test_transfer("thr_odd", 8'h3F, 1'b0, 1'b1, 3);
        test_transfer("rand_pg", 8'($urandom_range(8'h80, 8'hFF)), 1'b0, 1'($urandom), 2);
        test_reset_mid();
        test_no_trigger();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
